// File: rtl/result_display_scan.sv
// Two-digit sign-magnitude result display with multiplexed digit scan.
// Captures a strobed result and refreshes units/sign digits alternately.
module result_display_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] result_in,
  input  logic       result_valid,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp_n,
  output logic       shown
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] ERR_E = 7'b0000110;

  typedef enum logic {DIG0, DIG1} state_t;

  state_t      state;
  state_t      state_nx;
  logic [CW-1:0] cnt;
  logic        wrap;
  logic [4:0]  hold;
  logic [4:0]  hold_nx;
  logic        shown_nx;
  logic [6:0]  seg_d;
  logic [1:0]  an_d;

  function automatic logic [6:0] glyph(input logic [3:0] mag);
    logic [6:0] g;
    case (mag)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = ERR_E;
    endcase
    return g;
  endfunction

  assign wrap = (cnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= DIG0;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (wrap) begin
      unique case (state)
        DIG0: state_nx = DIG1;
        DIG1: state_nx = DIG0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      hold  <= 5'b0;
      shown <= 1'b0;
    end else begin
      cnt   <= wrap ? '0 : cnt + CW'(1);
      hold  <= hold_nx;
      shown <= shown_nx;
    end
  end

  // Outputs are computed from next-state values so they line up with the regs
  always_comb begin
    hold_nx  = result_valid ? result_in : hold;
    shown_nx = shown | result_valid;
    seg_d    = BLANK;
    an_d     = 2'b11;
    if (shown_nx) begin
      unique case (state_nx)
        DIG0: begin
          an_d  = 2'b10;
          seg_d = glyph(hold_nx[3:0]);
        end
        DIG1: begin
          an_d  = 2'b01;
          seg_d = (hold_nx[4] && hold_nx[3:0] != 4'd0) ? MINUS : BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg  <= BLANK;
      an   <= 2'b11;
      dp_n <= 1'b1;
    end else begin
      seg  <= seg_d;
      an   <= an_d;
      dp_n <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_display_scan.sv
// Directed per-cycle vector bench for result_display_scan, REFRESH_DIV=4.
// Each row gives inputs for one edge and the outputs expected just after it.
module tb_result_display_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] result_in = 5'b0;
  logic       result_valid = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp_n;
  logic       shown;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [4:0] res;
    logic [6:0] seg;
    logic [1:0] an;
    logic       shown;
  } vec_t;

  vec_t vecs[$];

  result_display_scan #(.REFRESH_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .result_in(result_in),
    .result_valid(result_valid),
    .seg(seg),
    .an(an),
    .dp_n(dp_n),
    .shown(shown)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic v, input logic [4:0] d,
                     input logic [6:0] s, input logic [1:0] a,
                     input logic sh, input int n = 1);
    vec_t t;
    t.rst = r; t.valid = v; t.res = d;
    t.seg = s; t.an = a; t.shown = sh;
    for (int i = 0; i < n; i++) vecs.push_back(t);
  endtask

  initial begin
    // reset held two cycles, then idle dark for 8
    add(1, 0, 5'h00, 7'h7F, 2'b11, 0, 2);
    add(0, 0, 5'h00, 7'h7F, 2'b11, 0, 8);
    // +6 captured at cnt 0 -> 1
    add(0, 1, 5'b0_0110, 7'h02, 2'b10, 1);
    add(0, 0, 5'h00, 7'h02, 2'b10, 1, 2);
    add(0, 0, 5'h00, 7'h7F, 2'b01, 1, 4);
    add(0, 0, 5'h00, 7'h02, 2'b10, 1);
    // -9
    add(0, 1, 5'b1_1001, 7'h10, 2'b10, 1);
    add(0, 0, 5'h00, 7'h10, 2'b10, 1, 2);
    add(0, 0, 5'h00, 7'h3F, 2'b01, 1, 4);
    add(0, 0, 5'h00, 7'h10, 2'b10, 1);
    // -0 shows plain zero, blank sign
    add(0, 1, 5'b1_0000, 7'h40, 2'b10, 1);
    add(0, 0, 5'h00, 7'h40, 2'b10, 1, 2);
    add(0, 0, 5'h00, 7'h7F, 2'b01, 1, 2);
    // +12 while sign digit active, then E on units
    add(0, 1, 5'b0_1100, 7'h7F, 2'b01, 1);
    add(0, 0, 5'h00, 7'h7F, 2'b01, 1);
    add(0, 0, 5'h00, 7'h06, 2'b10, 1, 4);
    // -3 strobed on the toggle edge
    add(0, 1, 5'b1_0011, 7'h3F, 2'b01, 1);
    add(0, 0, 5'h00, 7'h3F, 2'b01, 1, 3);
    add(0, 0, 5'h00, 7'h30, 2'b10, 1);
    // back-to-back strobes, last wins
    add(0, 1, 5'b0_0001, 7'h79, 2'b10, 1);
    add(0, 1, 5'b0_0010, 7'h24, 2'b10, 1);
    add(0, 0, 5'h00, 7'h24, 2'b10, 1);
    add(0, 0, 5'h00, 7'h7F, 2'b01, 1);
    // reset mid-scan with coincident strobe
    add(1, 1, 5'b1_0101, 7'h7F, 2'b11, 0);
    add(0, 0, 5'h00, 7'h7F, 2'b11, 0);
    // counter restarted at 0: toggle after 4 edges from reset
    add(0, 1, 5'b0_1000, 7'h00, 2'b10, 1);
    add(0, 0, 5'h00, 7'h00, 2'b10, 1);
    add(0, 0, 5'h00, 7'h7F, 2'b01, 1);
    add(0, 0, 5'h00, 7'h7F, 2'b01, 1, 3);
    add(0, 0, 5'h00, 7'h00, 2'b10, 1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      result_valid = vecs[i].valid;
      result_in = vecs[i].res;
      @(posedge clk);
      #1;
      checks++;
      if (seg !== vecs[i].seg) begin
        errors++;
        $display("FAIL seg row %0d: got %h want %h", i, seg, vecs[i].seg);
      end
      checks++;
      if (an !== vecs[i].an) begin
        errors++;
        $display("FAIL an row %0d: got %b want %b", i, an, vecs[i].an);
      end
      checks++;
      if (shown !== vecs[i].shown) begin
        errors++;
        $display("FAIL shown row %0d: got %b want %b", i, shown,
                 vecs[i].shown);
      end
      checks++;
      if (dp_n !== 1'b1) begin
        errors++;
        $display("FAIL dp_n row %0d: got %b want 1", i, dp_n);
      end
    end
    rst = 1'b0;
    result_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
